// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM states, default FIFO depth and byte width.
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    BUSY
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy level and full/empty flags.
// Written to be shared by both the transmit and the receive paths.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W = BYTE_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] level,
  output logic          empty,
  output logic          full
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Requests that would corrupt the pointers are ignored, and clear beats both.
  assign wr_en = push && !full && !clear;
  assign rd_en = pop && !empty && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that launches queued bytes into the UART transmitter, paced by tx_active.
// Optional synchronous flush port is enabled by defining UART_TX_FEEDER_FLUSH_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_active,
  output logic [CW-1:0]     level,
  output logic              empty,
  output logic              full,
  output logic              overflow
`ifdef UART_TX_FEEDER_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  feeder_state_e     state;
  feeder_state_e     state_next;
  logic              start_next;
  logic              launch;
  logic              push;
  logic              flush_req;
  logic [BYTE_W-1:0] head;

`ifdef UART_TX_FEEDER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready = !full;
  assign push     = in_valid && !full && !flush_req;

  uart_sync_fifo #(
    .DEPTH(DEPTH),
    .W    (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_req),
    .push     (push),
    .push_data(in_data),
    .pop      (launch),
    .head     (head),
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  // tx_done is deliberately ignored: it stays high until the next start, so only
  // the rise-then-fall of tx_active marks the end of a frame.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush_req) begin
          launch     = 1'b1;
          start_next = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:   state_next = WAIT_ACK;
      WAIT_ACK: if (tx_active) state_next = BUSY;
      BUSY:     if (!tx_active) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= start_next;
      if (launch) tx_data <= head;
      if (in_valid && full && !flush_req) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a queue-based reference model checked every cycle,
// a simple transmitter model driving tx_active, and hand-computed spot checks.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_active = 1'b0;
  logic [CW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int dut_launches = 0;
  int frame_len = 20;
  bit stuck = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_active(tx_active),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
`ifdef UART_TX_FEEDER_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transmitter stand-in: samples tx_start, then stays active for frame_len cycles.
  initial begin : transmitter
    int  busy_cnt;
    bit  pending;
    busy_cnt = 0;
    pending  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
        pending  = 1'b0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (pending) begin
          busy_cnt = frame_len;
          pending  = 1'b0;
        end
        if (tx_start) pending = 1'b1;
      end
      tx_active = stuck || (busy_cnt > 0);
    end
  end

  // Reference model: arrival-order byte queue plus the frame pacing rule
  // (a new byte may go out only once the previous frame's tx_active rose and fell).
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_start;
  logic [7:0] m_data;
  bit         free;
  bit         saw_active;
  bit         launch_now;
  bit         push_ok;
  bit         fl;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf      = 1'b0;
      m_start    = 1'b0;
      m_data     = 8'h00;
      free       = 1'b1;
      saw_active = 1'b0;
    end
    if (tx_start) dut_launches++;
    check_output("level", level, q.size());
    check_output("empty", empty, q.size() == 0);
    check_output("full", full, q.size() == DEPTH);
    check_output("in_ready", in_ready, q.size() < DEPTH);
    check_output("overflow", overflow, m_ovf);
    check_output("tx_start", tx_start, m_start);
    check_output("tx_data", tx_data, m_data);
    if (!rst) begin
`ifdef UART_TX_FEEDER_FLUSH_EN
      fl = flush;
`else
      fl = 1'b0;
`endif
      if (fl) q.delete();
      launch_now = free && (q.size() > 0) && !fl;
      push_ok    = in_valid && (q.size() < DEPTH) && !fl;
      if (in_valid && q.size() == DEPTH && !fl) m_ovf = 1'b1;
      if (!free && !m_start) begin
        if (!saw_active) begin
          if (tx_active) saw_active = 1'b1;
        end else if (!tx_active) begin
          free = 1'b1;
        end
      end
      m_start = launch_now;
      if (launch_now) begin
        m_data     = q.pop_front();
        free       = 1'b0;
        saw_active = 1'b0;
      end
      if (push_ok) q.push_back(in_data);
    end
  end

  // Each call defines the inputs seen at the next rising edge, then returns just after it.
  task automatic apply_stimulus(input logic valid, input logic [7:0] data);
    in_valid = valid;
    in_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) apply_stimulus(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    stuck    = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int budget);
    int n;
    n = 0;
    while (dut_launches < target && n < budget) begin
      apply_stimulus(1'b0, 8'h00);
      n++;
    end
    check_output("launch count", dut_launches, target);
  endtask

  initial begin : stimulus
    int base;
    int accepted;
    int k;
    bit offer;

    @(posedge clk);
    #1;
    check_output("reset tx_start", tx_start, 1'b0);
    check_output("reset tx_data", tx_data, 8'h00);
    check_output("reset in_ready", in_ready, 1'b1);
    check_output("reset level", level, 0);
    check_output("reset empty", empty, 1'b1);
    check_output("reset full", full, 1'b0);
    check_output("reset overflow", overflow, 1'b0);
    do_reset();

    $display("[TB] single byte launch");
    apply_stimulus(1'b1, 8'hA5);
    check_output("a5 level after push", level, 1);
    check_output("a5 empty after push", empty, 1'b0);
    check_output("a5 no early start", tx_start, 1'b0);
    apply_stimulus(1'b0, 8'h00);
    check_output("a5 start pulse", tx_start, 1'b1);
    check_output("a5 tx_data", tx_data, 8'hA5);
    check_output("a5 level drained", level, 0);
    check_output("a5 empty drained", empty, 1'b1);
    apply_stimulus(1'b0, 8'h00);
    check_output("a5 pulse one cycle", tx_start, 1'b0);
    idle_cycles(30);
    check_output("a5 single launch", dut_launches, 1);

    $display("[TB] 16-byte burst, 20-cycle frames");
    base = dut_launches;
    for (int i = 0; i < 16; i++) begin
      check_output("burst in_ready", in_ready, 1'b1);
      apply_stimulus(1'b1, 8'(i));
    end
    apply_stimulus(1'b0, 8'h00);
    wait_launches(base + 16, 16 * 26 + 50);
    check_output("burst last byte", tx_data, 8'h0F);
    idle_cycles(40);
    check_output("burst launches exact", dut_launches, base + 16);

    // One byte leaves for the transmitter before it sticks busy, so 17 fit in total.
    $display("[TB] transmitter stuck busy, handshake honored");
    do_reset();
    stuck    = 1'b1;
    accepted = 0;
    k        = 0;
    base     = dut_launches;
    repeat (20) begin
      offer = in_ready;
      apply_stimulus(offer, 8'(8'h40 + k));
      if (offer) begin
        accepted++;
        k++;
      end
    end
    apply_stimulus(1'b0, 8'h00);
    check_output("stuck accepted", accepted, 17);
    check_output("stuck level", level, 16);
    check_output("stuck full", full, 1'b1);
    check_output("stuck in_ready", in_ready, 1'b0);
    check_output("stuck overflow", overflow, 1'b0);
    check_output("stuck first byte", tx_data, 8'h40);

    $display("[TB] forced push while full");
    repeat (3) apply_stimulus(1'b1, 8'hEE);
    apply_stimulus(1'b0, 8'h00);
    check_output("ovf flag", overflow, 1'b1);
    check_output("ovf level", level, 16);
    frame_len = 3;
    stuck     = 1'b0;
    wait_launches(base + 17, 16 * 12 + 50);
    check_output("ovf last byte", tx_data, 8'h50);
    check_output("ovf sticky", overflow, 1'b1);
    idle_cycles(10);

    $display("[TB] reset while busy with bytes queued");
    do_reset();
    frame_len = 20;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'(8'h60 + i));
    idle_cycles(6);
    check_output("pre-reset level", level, 5);
    rst = 1'b1;
    #1;
    check_output("mid reset level", level, 0);
    check_output("mid reset tx_start", tx_start, 1'b0);
    check_output("mid reset in_ready", in_ready, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    base = dut_launches;
    idle_cycles(40);
    check_output("no launch after reset", dut_launches, base);

`ifdef UART_TX_FEEDER_FLUSH_EN
    $display("[TB] flush with frame in flight");
    do_reset();
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'(8'h80 + i));
    idle_cycles(4);
    check_output("pre-flush level", level, 8);
    flush = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    flush = 1'b0;
    check_output("flush level", level, 0);
    base = dut_launches;
    idle_cycles(40);
    check_output("no launch after flush", dut_launches, base);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
